// File: rtl/axis_read_data.sv
// Unpacks AXI R beats into DATA_WIDTH words; word 0 of a beat is valid two clocks after acceptance.
// Backpressure: valid/ready stream stalls the serializer, a full buffer drops axi_rready. Option: AXIS_READ_DATA_RRESP_EN.
module axis_read_data #(
  parameter int BUF_AWIDTH     = 4,
  parameter int CONFIG_DWIDTH  = 32,
  parameter int WIDTH_RATIO    = 8,
  parameter int AXI_DATA_WIDTH = 256,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      done,
  input  logic [CONFIG_DWIDTH-1:0]  cfg_length,
  input  logic                      cfg_valid,
  input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  input  logic                      axi_rlast,
  input  logic                      axi_rvalid,
  output logic                      axi_rready,
`ifdef AXIS_READ_DATA_RRESP_EN
  input  logic [1:0]                axi_rresp,
  output logic                      err,
`endif
  output logic [DATA_WIDTH-1:0]     data,
  output logic                      valid,
  input  logic                      ready
);

  localparam int DEPTH = 1 << BUF_AWIDTH;
  localparam int CW    = $clog2(WIDTH_RATIO + 1);
  localparam logic [CW-1:0]            RATIO_W = CW'(WIDTH_RATIO);
  localparam logic [CONFIG_DWIDTH-1:0] RATIO_C = CONFIG_DWIDTH'(WIDTH_RATIO);
  localparam logic [CONFIG_DWIDTH-1:0] ONE_C   = CONFIG_DWIDTH'(1);
  localparam logic [BUF_AWIDTH:0]      DEPTH_W = {1'b1, {BUF_AWIDTH{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;
  state_t state, state_nxt;

  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];
  logic [BUF_AWIDTH:0]       wr_ptr, rd_ptr, fifo_cnt, occ_nxt;
  logic [AXI_DATA_WIDTH-1:0] sh_dat;
  logic [CW-1:0]             sh_cnt, last_words, pop_words;
  logic [CONFIG_DWIDTH-1:0]  beats_rem, beats_nxt, pop_rem, words_rem, beats_cfg, rem_cfg;
  logic                      cfg_load, wr, pop, out_load, out_xfer, sh_busy_nxt;
  logic                      unused_rlast;

  assign unused_rlast = axi_rlast;
  assign done         = (state == S_DONE);
  assign cfg_load     = (state == S_IDLE) && cfg_valid;
  assign wr           = axi_rvalid && axi_rready;
  assign fifo_cnt     = wr_ptr - rd_ptr;
  assign out_xfer     = valid && ready;
  assign out_load     = (sh_cnt != '0) && (!valid || ready);
  // Refill the serializer as its last word moves out, so beats stream back to back.
  assign pop          = (fifo_cnt != '0) && ((sh_cnt == '0) || ((sh_cnt == CW'(1)) && out_load));
  assign pop_words    = (pop_rem == ONE_C) ? last_words : RATIO_W;
  assign rem_cfg      = cfg_length % RATIO_C;
  assign beats_cfg    = (cfg_length / RATIO_C) + {{(CONFIG_DWIDTH-1){1'b0}}, (rem_cfg != '0)};

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cfg_valid) state_nxt = (cfg_length == '0) ? S_DONE : S_ACTIVE;
      S_ACTIVE: if (out_xfer && (words_rem == ONE_C)) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // The beat parked in the serializer counts toward occupancy, so at most DEPTH beats are held.
  always_comb begin
    beats_nxt = beats_rem;
    if (cfg_load)  beats_nxt = beats_cfg;
    else if (wr)   beats_nxt = beats_rem - ONE_C;
    sh_busy_nxt = (sh_cnt != '0);
    if (pop)                                   sh_busy_nxt = 1'b1;
    else if (out_load && (sh_cnt == CW'(1)))   sh_busy_nxt = 1'b0;
    occ_nxt = fifo_cnt + {{BUF_AWIDTH{1'b0}}, wr} - {{BUF_AWIDTH{1'b0}}, pop}
              + {{BUF_AWIDTH{1'b0}}, sh_busy_nxt};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr[BUF_AWIDTH-1:0]] <= axi_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      beats_rem  <= '0;
      pop_rem    <= '0;
      words_rem  <= '0;
      last_words <= '0;
      sh_dat     <= '0;
      sh_cnt     <= '0;
      data       <= '0;
      valid      <= 1'b0;
      axi_rready <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + {{BUF_AWIDTH{1'b0}}, wr};
      rd_ptr     <= rd_ptr + {{BUF_AWIDTH{1'b0}}, pop};
      beats_rem  <= beats_nxt;
      axi_rready <= (state_nxt == S_ACTIVE) && (occ_nxt != DEPTH_W) && (beats_nxt != '0);
      if (cfg_load) begin
        pop_rem    <= beats_cfg;
        words_rem  <= cfg_length;
        last_words <= (rem_cfg == '0) ? RATIO_W : rem_cfg[CW-1:0];
      end else begin
        if (pop)      pop_rem   <= pop_rem - ONE_C;
        if (out_xfer) words_rem <= words_rem - ONE_C;
      end
      if (pop) begin
        sh_dat <= mem[rd_ptr[BUF_AWIDTH-1:0]];
        sh_cnt <= pop_words;
      end else if (out_load) begin
        sh_dat <= sh_dat >> DATA_WIDTH;
        sh_cnt <= sh_cnt - CW'(1);
      end
      if (out_load) begin
        data  <= sh_dat[DATA_WIDTH-1:0];
        valid <= 1'b1;
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

`ifdef AXIS_READ_DATA_RRESP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             err <= 1'b0;
    else if (cfg_load)                   err <= 1'b0;
    else if (wr && (axi_rresp != 2'b00)) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_axis_read_data.sv
// Directed bench for axis_read_data with a word scoreboard fed from the beat source.
module tb_axis_read_data;
  localparam int R   = 8;
  localparam int DW  = 32;
  localparam int AWD = 256;
  localparam int CDW = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           done;
  logic [CDW-1:0] cfg_length = '0;
  logic           cfg_valid = 1'b0;
  logic [AWD-1:0] axi_rdata = '0;
  logic           axi_rlast = 1'b0;
  logic           axi_rvalid = 1'b0;
  logic           axi_rready;
  logic [DW-1:0]  data;
  logic           valid;
  logic           ready = 1'b0;
`ifdef AXIS_READ_DATA_RRESP_EN
  logic [1:0]     axi_rresp = 2'b00;
  logic           err;
`endif

  axis_read_data dut (
    .clk(clk), .rst(rst), .done(done),
    .cfg_length(cfg_length), .cfg_valid(cfg_valid),
    .axi_rdata(axi_rdata), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
`ifdef AXIS_READ_DATA_RRESP_EN
    .axi_rresp(axi_rresp), .err(err),
`endif
    .data(data), .valid(valid), .ready(ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int exp_q[$];
  int beats, done_cnt, done_cyc, hs_cnt, first_hs, last_hs, acc0_cyc;
  bit xfer_end, prev_stall;
  logic [DW-1:0] prev_data;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [AWD-1:0] mk_beat(input int tag, input int b);
    logic [AWD-1:0] v;
    v = '0;
    for (int k = 0; k < R; k++) v[k*DW +: DW] = DW'(tag + b*R + k + 1);
    return v;
  endfunction

  // mode 0: sink always ready; 1: ready toggles, cfg re-pulsed mid-transfer; 2: ready held low 40 cycles
  task automatic run_xfer(input int len, input int mode, input int tag, input int err_beat,
                          input int exp_beats, input int budget);
    bit acc;
    int n_sink, n_wd, after;
    xfer_end = 0; beats = 0; done_cnt = 0; done_cyc = -1; hs_cnt = 0;
    first_hs = -1; last_hs = -1; acc0_cyc = -1; prev_stall = 0;
    n_sink = 0; n_wd = 0; after = -1;
    cfg_length = CDW'(len);
    cfg_valid  = 1'b1;
    ready      = (mode == 0);
    axi_rvalid = 1'b1;
    axi_rdata  = mk_beat(tag, 0);
`ifdef AXIS_READ_DATA_RRESP_EN
    axi_rresp  = (err_beat == 0) ? 2'b10 : 2'b00;
`endif
    fork
      begin
        while (!xfer_end) begin
          @(negedge clk);
          acc = axi_rready;
          if (acc && beats == 0) acc0_cyc = cyc;
          @(posedge clk); #1;
          if (acc) begin
            for (int k = 0; k < R; k++)
              if (beats*R + k < len) exp_q.push_back(tag + beats*R + k + 1);
`ifdef AXIS_READ_DATA_RRESP_EN
            if (err_beat >= 0) check("err_track", err, (beats >= err_beat) ? 1 : 0);
`endif
            beats++;
            axi_rdata = mk_beat(tag, beats);
`ifdef AXIS_READ_DATA_RRESP_EN
            axi_rresp = (beats == err_beat) ? 2'b10 : 2'b00;
`endif
          end
        end
        axi_rvalid = 1'b0;
      end
      begin
        while (!xfer_end) begin
          @(posedge clk); #1;
          n_sink++;
          if (n_sink == 1) cfg_valid = 1'b0;
          if (mode == 1) begin
            ready = ~ready;
            if (n_sink == 6) begin cfg_length = CDW'(8); cfg_valid = 1'b1; end
            if (n_sink == 7) cfg_valid = 1'b0;
          end else if (mode == 2 && n_sink == 40) begin
            @(negedge clk);
            check("fill_beats", beats, 16);
            check("fill_rready", axi_rready, 0);
            check("fill_valid", valid, 1);
            @(posedge clk); #1;
            ready = 1'b1;
          end
        end
      end
      begin
        while (!xfer_end) begin
          @(negedge clk);
          if (prev_stall) check("hold_data", data, prev_data);
          if (valid && ready) begin
            total++;
            assert (exp_q.size() > 0) else begin
              bad++;
              $error("FAIL unexpected_word observed=%0h expected=none", data);
            end
            if (exp_q.size() > 0) check("data", data, exp_q.pop_front());
            hs_cnt++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
          end
          prev_stall = valid && !ready;
          prev_data  = data;
        end
      end
      begin
        while (!xfer_end) begin
          @(negedge clk);
          n_wd++;
          if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
          end
          if (done_cnt > 0) after++;
          if (after == 5 || n_wd >= budget) xfer_end = 1;
        end
      end
    join
    @(negedge clk);
    check("done_count", done_cnt, 1);
    check("beats", beats, exp_beats);
    check("words", hs_cnt, len);
    check("leftover", exp_q.size(), 0);
    check("rready_after", axi_rready, 0);
    check("valid_after", valid, 0);
    exp_q.delete();
  endtask

  initial begin
    repeat (6) begin
      @(negedge clk);
      check("rst_done", done, 0);
      check("rst_rready", axi_rready, 0);
      check("rst_valid", valid, 0);
      check("rst_data", data, 0);
`ifdef AXIS_READ_DATA_RRESP_EN
      check("rst_err", err, 0);
`endif
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_rready", axi_rready, 0);
      check("post_rst_valid", valid, 0);
      check("post_rst_data", data, 0);
    end

    run_xfer(8, 0, 0, -1, 1, 200);
    check("latency_first_word", first_hs, acc0_cyc + 3);
    check("consecutive_words", last_hs - first_hs, 7);
    check("done_after_last", done_cyc, last_hs + 1);

    run_xfer(12, 1, 0, -1, 2, 300);

    run_xfer(4092, 2, 4096, -1, 512, 6000);

`ifdef AXIS_READ_DATA_RRESP_EN
    run_xfer(24, 0, 9000, 1, 3, 300);
    check("err_sticky", err, 1);
`endif

    cfg_length = '0;
    cfg_valid  = 1'b1;
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_rready", axi_rready, 0);
`ifdef AXIS_READ_DATA_RRESP_EN
    check("err_cleared", err, 0);
`endif
    cfg_valid = 1'b0;
    @(negedge clk);
    check("zero_done_end", done, 0);
    check("zero_rready_end", axi_rready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
